// File: rtl/nibbler_ram_pkg.sv
// Shared definitions for the NibblER RAM bus master.
//   DATA_WIDTH / ADDR_WIDTH : RAM word and address widths (4 x 4096)
//   ACC_CNT_W               : width of the ACCESS-phase down-counter (ACCESS_CYCLES <= 2**ACC_CNT_W)
//   ram_state_t             : bus-cycle FSM states
//   acc_load()              : counter preload for a given number of ACCESS cycles
package nibbler_ram_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int ADDR_WIDTH = 12;
    localparam int ACC_CNT_W  = 4;

    typedef enum logic [2:0] {
        RS_IDLE    = 3'd0,
        RS_SETUP   = 3'd1,
        RS_ACCESS  = 3'd2,
        RS_RELEASE = 3'd3,
        RS_CLEAR   = 3'd4
    } ram_state_t;

    // The counter runs from cycles-1 down to 0, so the last ACCESS cycle is the one seeing 0.
    function automatic logic [ACC_CNT_W-1:0] acc_load(input int unsigned cycles);
        logic [ACC_CNT_W-1:0] c;
        c = cycles[ACC_CNT_W-1:0];
        return c - {{(ACC_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ram_data_iobuf.sv
// Tri-state pad for the RAM data bus; the only tri-state driver in the bus master.
//   oe_i   : drive enable (write cycles only)
//   dout_i : value driven onto the pad when oe_i is high
//   din_o  : pad value as seen by the core (read data path)
//   pad_io : the shared RAM data bus
module ram_data_iobuf #(
    parameter int W = 4
) (
    input  logic         oe_i,
    input  logic [W-1:0] dout_i,
    output logic [W-1:0] din_o,
    inout  wire  [W-1:0] pad_io
);

    assign pad_io = oe_i ? dout_i : {W{1'bz}};
    assign din_o  = pad_io;

endmodule

// File: rtl/ram_bus_master.sv
// Clocked initiator for the asynchronous 4-bit x 4096 RAM bus.
// Turns single-cycle CPU requests into SETUP / ACCESS(xN) / RELEASE bus cycles and owns
// the tri-state data bus (driven only during write cycles).
// Optional feature macro: RAM_CLEAR_EN -- after reset, sweep-write 0 to every RAM word
// before accepting requests (busy_clr high during the sweep).
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   req, req_we           : request strobe (taken when req && ready), 1 = write
//   req_addr, req_wdata   : request address / write data
//   ready                 : idle, request can be accepted
//   busy_clr              : clear sweep in progress (tied 0 without RAM_CLEAR_EN)
//   rdata, rvalid         : read data, one-cycle completion pulse
//   address, data, cs, we : RAM bus
module ram_bus_master
    import nibbler_ram_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  busy_clr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  cs,
    output logic                  we
);

    localparam logic [ACC_CNT_W-1:0] ACC_LOAD = acc_load(ACCESS_CYCLES);
    localparam logic [ACC_CNT_W-1:0] CNT_ONE  = {{(ACC_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_CNT_W-1:0] CNT_ZERO = {ACC_CNT_W{1'b0}};

    ram_state_t            state_q, state_d;
    logic [ACC_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  cs_q, cs_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] din_s;
`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    logic                  busy_clr_q, busy_clr_d;
`endif

    ram_data_iobuf #(
        .W(DATA_WIDTH)
    ) u_iobuf (
        .oe_i  (oe_q),
        .dout_i(wdata_q),
        .din_o (din_s),
        .pad_io(data)
    );

    // Next-state logic for the bus-cycle FSM and all registered bus outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        oe_d     = oe_q;
        cs_d     = cs_q;
        rvalid_d = 1'b0;
        ready_d  = 1'b0;
`ifdef RAM_CLEAR_EN
        busy_clr_d = busy_clr_q;
`endif
        case (state_q)
            RS_IDLE: begin
                if (req && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    oe_d    = req_we;
                    state_d = RS_SETUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            RS_SETUP: begin
                cs_d    = 1'b1;
                cnt_d   = ACC_LOAD;
                state_d = RS_ACCESS;
            end
            RS_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    // Read data is captured on the same edge that drops cs.
                    cs_d    = 1'b0;
                    state_d = RS_RELEASE;
                    if (!we_q) begin
                        rdata_d  = din_s;
                        rvalid_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RS_RELEASE: begin
                // RELEASE itself is the write hold cycle; we/data drop on leaving it.
                we_d = 1'b0;
                oe_d = 1'b0;
`ifdef RAM_CLEAR_EN
                if (busy_clr_q && (addr_q != {ADDR_WIDTH{1'b1}})) begin
                    addr_d  = addr_q + ADDR_ONE;
                    we_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = RS_SETUP;
                end else begin
                    busy_clr_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = RS_IDLE;
                end
`else
                ready_d = 1'b1;
                state_d = RS_IDLE;
`endif
            end
            RS_CLEAR: begin
`ifdef RAM_CLEAR_EN
                busy_clr_d = 1'b1;
                addr_d     = {ADDR_WIDTH{1'b0}};
                wdata_d    = {DATA_WIDTH{1'b0}};
                we_d       = 1'b1;
                oe_d       = 1'b1;
                state_d    = RS_SETUP;
`else
                state_d = RS_IDLE;
`endif
            end
            default: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                oe_d    = 1'b0;
                state_d = RS_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RAM_CLEAR_EN
            state_q    <= RS_CLEAR;
            busy_clr_q <= 1'b0;
`else
            state_q    <= RS_IDLE;
`endif
            cnt_q    <= CNT_ZERO;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            rdata_q  <= {DATA_WIDTH{1'b0}};
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            cs_q     <= 1'b0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
`ifdef RAM_CLEAR_EN
            busy_clr_q <= busy_clr_d;
`endif
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            cs_q     <= cs_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign address = addr_q;
    assign cs      = cs_q;
    assign we      = we_q;
`ifdef RAM_CLEAR_EN
    assign busy_clr = busy_clr_q;
`else
    assign busy_clr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: three instances (ACCESS_CYCLES = 2, 1, 4), each
// with its own behavioural asynchronous RAM acting as bus slave, driven by directed vectors.
module tb_ram_bus_master;

    localparam int N0 = 2;
    localparam int N1 = 1;
    localparam int N2 = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_v = 3'b000;
    logic [2:0]  rwe_v = 3'b000;
    logic [11:0] raddr_v  [3];
    logic [3:0]  rwdata_v [3];

    wire  [2:0]  ready_v, busy_v, rvalid_v, cs_v, we_v;
    wire  [3:0]  rdata_v [3];
    wire  [11:0] addr_v  [3];
    wire  [3:0]  d0, d1, d2;

    logic [3:0]  mem0 [4096];
    logic [3:0]  mem1 [4096];
    logic [3:0]  mem2 [4096];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rd0 = 0;
    int rv_cnt0 = 0;
    int viol_stab = 0;
    int viol_bus  = 0;
    int cs_hi [3];
    int tail  [3];
    logic [11:0] prev_addr [3];
    logic        prev_we   [3];

    ram_bus_master #(.ACCESS_CYCLES(N0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .req_we(rwe_v[0]), .req_addr(raddr_v[0]),
        .req_wdata(rwdata_v[0]), .ready(ready_v[0]), .busy_clr(busy_v[0]), .rdata(rdata_v[0]),
        .rvalid(rvalid_v[0]), .address(addr_v[0]), .data(d0), .cs(cs_v[0]), .we(we_v[0])
    );
    ram_bus_master #(.ACCESS_CYCLES(N1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .req_we(rwe_v[1]), .req_addr(raddr_v[1]),
        .req_wdata(rwdata_v[1]), .ready(ready_v[1]), .busy_clr(busy_v[1]), .rdata(rdata_v[1]),
        .rvalid(rvalid_v[1]), .address(addr_v[1]), .data(d1), .cs(cs_v[1]), .we(we_v[1])
    );
    ram_bus_master #(.ACCESS_CYCLES(N2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req_v[2]), .req_we(rwe_v[2]), .req_addr(raddr_v[2]),
        .req_wdata(rwdata_v[2]), .ready(ready_v[2]), .busy_clr(busy_v[2]), .rdata(rdata_v[2]),
        .rvalid(rvalid_v[2]), .address(addr_v[2]), .data(d2), .cs(cs_v[2]), .we(we_v[2])
    );

    // RAM slaves: drive data only when cs && !we, write while cs && we.
    assign d0 = (cs_v[0] && !we_v[0]) ? mem0[addr_v[0]] : 4'bzzzz;
    assign d1 = (cs_v[1] && !we_v[1]) ? mem1[addr_v[1]] : 4'bzzzz;
    assign d2 = (cs_v[2] && !we_v[2]) ? mem2[addr_v[2]] : 4'bzzzz;

    always @(posedge clk) begin
        if (cs_v[0] && we_v[0]) mem0[addr_v[0]] <= d0;
        if (cs_v[1] && we_v[1]) mem1[addr_v[1]] <= d1;
        if (cs_v[2] && we_v[2]) mem2[addr_v[2]] <= d2;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: cs width, write hold length, address/we stability, contention.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (req_v[i] && ready_v[i]) begin
                cs_hi[i] = 0;
                tail[i]  = 0;
            end
            if (cs_v[i]) cs_hi[i]++;
            if (we_v[i] && !cs_v[i] && cs_hi[i] > 0) tail[i]++;
            if (cs_v[i] && (addr_v[i] !== prev_addr[i] || we_v[i] !== prev_we[i])) viol_stab++;
            prev_addr[i] = addr_v[i];
            prev_we[i]   = we_v[i];
        end
        if (rvalid_v[0]) rv_cnt0++;
        if (cs_v[0] && !we_v[0] && (u_dut0.u_iobuf.oe_i || $isunknown(d0))) viol_bus++;
        if (we_v[0] && $isunknown(d0)) viol_bus++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on instance i; returns read latency (cycles after accept) and read data.
    task automatic issue(input int i, input logic w, input logic [11:0] a, input logic [3:0] wd,
                         output int lat, output logic [3:0] rd);
        int n;
        n = 0;
        while (!ready_v[i] && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check("ready_wait", n, 0);
        rwe_v[i] = w; raddr_v[i] = a; rwdata_v[i] = wd; req_v[i] = 1'b1;
        @(posedge clk); #1;
        req_v[i] = 1'b0;
        if (i == 0 && !w) n_rd0++;
        lat = 0;
        rd  = 4'h0;
        if (!w) begin
            lat = 1;
            while (!rvalid_v[i] && lat < 40) begin @(posedge clk); #1; lat++; end
            rd = rdata_v[i];
        end
        n = 0;
        while (!ready_v[i] && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check("ready_return", n, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, n, acc, budget, last_acc, nn;
        logic [3:0] rd, exp_w;
        logic r;
        for (int i = 0; i < 3; i++) begin
            raddr_v[i] = 12'h000; rwdata_v[i] = 4'h0;
            cs_hi[i] = 0; tail[i] = 0; prev_addr[i] = 12'h000; prev_we[i] = 1'b0;
        end
        for (int k = 0; k < 4096; k++) begin
`ifdef RAM_CLEAR_EN
            mem0[k] = 4'hF; mem1[k] = 4'hF; mem2[k] = 4'hF;
`else
            mem0[k] = 4'h0; mem1[k] = 4'h0; mem2[k] = 4'h0;
`endif
        end

        // Reset values
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", ready_v[0], 1'b0);
        check("rst_cs", cs_v[0], 1'b0);
        check("rst_we", we_v[0], 1'b0);
        check("rst_addr", addr_v[0], 12'h000);
        check("rst_rvalid", rvalid_v[0], 1'b0);
        check("rst_rdata", rdata_v[0], 4'h0);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_drive", u_dut0.u_iobuf.oe_i, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
`ifdef RAM_CLEAR_EN
        check("clr_entry_ready", ready_v[0], 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("clr_mid_busy", busy_v[0], 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("clr_rst_busy", busy_v[0], 1'b0);
        check("clr_rst_cs", cs_v[0], 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("clr_restart_busy", busy_v[0], 1'b1);
        check("clr_restart_addr", addr_v[0], 12'h000);
        n = 0;
        while (busy_v[0] && n < 20000) begin n++; @(posedge clk); #1; end
        check("clr_len", n, 4096 * (N0 + 2));
        check("clr_done_ready", ready_v[0], 1'b1);
        n = 0;
        while (ready_v != 3'b111 && n < 20000) begin n++; @(posedge clk); #1; end
        check("clr_all_ready", ready_v, 3'b111);
        issue(0, 1'b0, 12'h000, 4'h0, lat, rd); check("clr_rd_000", rd, 4'h0);
        issue(0, 1'b0, 12'h7FF, 4'h0, lat, rd); check("clr_rd_7ff", rd, 4'h0);
        issue(0, 1'b0, 12'hFFF, 4'h0, lat, rd); check("clr_rd_fff", rd, 4'h0);
`else
        check("idle_ready", ready_v[0], 1'b1);
`endif

        // Write then read back, latency N+2
        issue(0, 1'b1, 12'h123, 4'hA, lat, rd);
        check("wr_cs_width", cs_hi[0], N0);
        check("wr_hold", tail[0], 1);
        issue(0, 1'b0, 12'h123, 4'h0, lat, rd);
        check("rd_latency", lat, N0 + 2);
        check("rd_123", rd, 4'hA);
        check("rd_cs_width", cs_hi[0], N0);

        // Address extremes, no aliasing, rdata holds across a write
        issue(0, 1'b1, 12'hFFF, 4'h5, lat, rd);
        issue(0, 1'b1, 12'h000, 4'h3, lat, rd);
        issue(0, 1'b0, 12'hFFF, 4'h0, lat, rd);
        check("rd_fff", rd, 4'h5);
        issue(0, 1'b0, 12'h000, 4'h0, lat, rd);
        check("rd_000", rd, 4'h3);
        issue(0, 1'b1, 12'h456, 4'h9, lat, rd);
        check("rdata_hold", rdata_v[0], 4'h3);

        // req held high, alternating write/read
        rwe_v[0] = 1'b1; raddr_v[0] = 12'h055; rwdata_v[0] = 4'h7; req_v[0] = 1'b1;
        exp_w = 4'h0; acc = 0; budget = 0; last_acc = 0;
        while (acc < 4 && budget < 60) begin
            r = ready_v[0];
            @(posedge clk); #1;
            budget++;
            if (rvalid_v[0]) check("b2b_rdata", rdata_v[0], exp_w);
            if (r) begin
                acc++;
                if (acc > 1) check("b2b_gap", cyc - last_acc, N0 + 3);
                last_acc = cyc;
                if (rwe_v[0]) begin
                    exp_w = rwdata_v[0];
                    rwe_v[0] = 1'b0;
                end else begin
                    n_rd0++;
                    rwe_v[0] = 1'b1;
                    rwdata_v[0] = 4'hC;
                end
            end
        end
        req_v[0] = 1'b0;
        check("b2b_accepts", acc, 4);
        n = 0;
        while (!rvalid_v[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_rdata_last", rdata_v[0], 4'hC);
        n = 0;
        while (!ready_v[0] && n < 20) begin @(posedge clk); #1; n++; end

        // Other ACCESS_CYCLES values
        for (int j = 1; j < 3; j++) begin
            nn = (j == 1) ? N1 : N2;
            issue(j, 1'b1, 12'h3C0 + 12'(j), 4'h6 + 4'(j), lat, rd);
            check("n_wr_cs_width", cs_hi[j], nn);
            check("n_wr_hold", tail[j], 1);
            issue(j, 1'b0, 12'h3C0 + 12'(j), 4'h0, lat, rd);
            check("n_rd_latency", lat, nn + 2);
            check("n_rd_cs_width", cs_hi[j], nn);
            check("n_rd_data", rd, 4'h6 + 4'(j));
        end

        // Reset in the 2nd ACCESS cycle of a read
        n = 0;
        while (!ready_v[0] && n < 20) begin @(posedge clk); #1; n++; end
        rwe_v[0] = 1'b0; raddr_v[0] = 12'h123; req_v[0] = 1'b1;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_cs_before", cs_v[0], 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_cs", cs_v[0], 1'b0);
        check("abort_we", we_v[0], 1'b0);
        check("abort_drive", u_dut0.u_iobuf.oe_i, 1'b0);
        check("abort_rvalid", rvalid_v[0], 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
`ifdef RAM_CLEAR_EN
        check("abort_busy", busy_v[0], 1'b1);
`else
        check("abort_ready", ready_v[0], 1'b1);
`endif
        repeat (6) @(posedge clk);
        #1;

        check("rvalid_count", rv_cnt0, n_rd0);
        check("cs_stability", viol_stab, 0);
        check("bus_contention", viol_bus, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
